// File: rtl/vliw_pkg.sv
// vliw_pkg: shared forward-code type for the VLIW forwarding scoreboard
package vliw_pkg;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10} fwd_t;
endpackage

// File: rtl/vliw_fwd_pick.sv
// vliw_fwd_pick: picks the forward source for one operand, M over W, highest lane wins
module vliw_fwd_pick
  import vliw_pkg::*;
#(
  parameter int NLANES = 4,
  parameter int REGBITS = 5,
  localparam int LANEBITS = $clog2(NLANES)
) (
  input  logic [REGBITS-1:0]        i_src,
  input  logic [NLANES*REGBITS-1:0] i_rd_m,
  input  logic [NLANES-1:0]         i_v_m,
  input  logic [NLANES*REGBITS-1:0] i_rd_w,
  input  logic [NLANES-1:0]         i_v_w,
  output fwd_t                      o_fwd,
  output logic [LANEBITS-1:0]       o_sel
);
  logic                w_hit_m, w_hit_w;
  logic [LANEBITS-1:0] w_sel_m, w_sel_w;
  // ascending scan so the youngest (highest) matching lane overwrites older ones
  always_comb begin
    w_hit_m = 1'b0;
    w_hit_w = 1'b0;
    w_sel_m = '0;
    w_sel_w = '0;
    for (int j = 0; j < NLANES; j++) begin
      if (i_v_m[j] && i_rd_m[j*REGBITS +: REGBITS] == i_src) begin
        w_hit_m = 1'b1;
        w_sel_m = LANEBITS'(j);
      end
      if (i_v_w[j] && i_rd_w[j*REGBITS +: REGBITS] == i_src) begin
        w_hit_w = 1'b1;
        w_sel_w = LANEBITS'(j);
      end
    end
  end
  assign o_fwd = (i_src == '0) ? FWD_RF : w_hit_m ? FWD_M : w_hit_w ? FWD_W : FWD_RF;
  assign o_sel = (i_src == '0) ? '0 : w_hit_m ? w_sel_m : w_hit_w ? w_sel_w : '0;
endmodule

// File: rtl/vliw_fwd_scoreboard.sv
// vliw_fwd_scoreboard: per-lane forwarding, load-use stall and long-latency busy scoreboard
module vliw_fwd_scoreboard
  import vliw_pkg::*;
#(
  parameter int NLANES = 4,
  parameter int NREGS = 32,
  localparam int LANEBITS = $clog2(NLANES),
  localparam int REGBITS = $clog2(NREGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       StallE,
  input  logic                       FlushE,
  input  logic                       StallM,
  input  logic                       FlushM,
  input  logic                       StallW,
  input  logic                       FlushW,
  input  logic [NLANES*REGBITS-1:0]  Rs1D,
  input  logic [NLANES*REGBITS-1:0]  Rs2D,
  input  logic [NLANES*REGBITS-1:0]  RdD,
  input  logic [NLANES-1:0]          RegWriteD,
  input  logic [NLANES-1:0]          LoadD,
  input  logic [NLANES-1:0]          LongLatD,
  input  logic [NLANES-1:0]          LongDoneW,
  input  logic [NLANES*REGBITS-1:0]  LongRdW,
  output logic [NLANES*2-1:0]        ForwardAE,
  output logic [NLANES*2-1:0]        ForwardBE,
  output logic [NLANES*LANEBITS-1:0] FwdSelRs1E,
  output logic [NLANES*LANEBITS-1:0] FwdSelRs2E,
  output logic                       StallD
);
  logic [NLANES*REGBITS-1:0] r_rs1_e, r_rs2_e, r_rd_e, r_rd_m, r_rd_w;
  logic [NLANES-1:0]         r_rw_e, r_ld_e, r_ll_e, r_rw_m, r_ld_m, r_ll_m, r_rw_w, r_ll_w;
  logic [NREGS-1:0]          r_busy, w_busy_nxt, w_set, w_clr;
  logic [NLANES-1:0]         w_v_m, w_v_w;
  logic                      w_stall;
  // D->E register: flush bubbles the control bits, stall holds everything
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rs1_e <= '0;
      r_rs2_e <= '0;
      r_rd_e  <= '0;
      r_rw_e  <= '0;
      r_ld_e  <= '0;
      r_ll_e  <= '0;
    end else begin
      if (FlushE | ~StallE) begin
        r_rs1_e <= Rs1D;
        r_rs2_e <= Rs2D;
        r_rd_e  <= RdD;
      end
      if (FlushE) begin
        r_rw_e <= '0;
        r_ld_e <= '0;
        r_ll_e <= '0;
      end else if (~StallE) begin
        r_rw_e <= RegWriteD;
        r_ld_e <= LoadD;
        r_ll_e <= LongLatD;
      end
    end
  end
  // E->M register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_m <= '0;
      r_rw_m <= '0;
      r_ld_m <= '0;
      r_ll_m <= '0;
    end else begin
      if (FlushM | ~StallM) r_rd_m <= r_rd_e;
      if (FlushM) begin
        r_rw_m <= '0;
        r_ld_m <= '0;
        r_ll_m <= '0;
      end else if (~StallM) begin
        r_rw_m <= r_rw_e;
        r_ld_m <= r_ld_e;
        r_ll_m <= r_ll_e;
      end
    end
  end
  // M->W register; loads in W forward like any other result, so Load is not kept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_w <= '0;
      r_rw_w <= '0;
      r_ll_w <= '0;
    end else begin
      if (FlushW | ~StallW) r_rd_w <= r_rd_m;
      if (FlushW) begin
        r_rw_w <= '0;
        r_ll_w <= '0;
      end else if (~StallW) begin
        r_rw_w <= r_rw_m;
        r_ll_w <= r_ll_m;
      end
    end
  end
  // busy update: clear on long-latency writeback, set on long op leaving E, set wins, x0 never busy
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int j = 0; j < NLANES; j++) begin
      if (LongDoneW[j]) w_clr[LongRdW[j*REGBITS +: REGBITS]] = 1'b1;
      if (~StallM & ~FlushM & r_rw_e[j] & r_ll_e[j]) w_set[r_rd_e[j*REGBITS +: REGBITS]] = 1'b1;
    end
    w_busy_nxt = (r_busy & ~w_clr) | w_set;
    w_busy_nxt[0] = 1'b0;
  end
  // busy scoreboard register
  always_ff @(posedge clk) begin
    if (reset) r_busy <= '0;
    else r_busy <= w_busy_nxt;
  end
  function automatic logic src_haz(input logic [REGBITS-1:0] s);
    src_haz = 1'b0;
    if (s != '0) begin
      src_haz = r_busy[s] & ~w_clr[s];
      for (int j = 0; j < NLANES; j++)
        if (r_rw_e[j] & (r_ld_e[j] | r_ll_e[j]) & (r_rd_e[j*REGBITS +: REGBITS] == s)) src_haz = 1'b1;
    end
  endfunction
  // bundle stall: load-use or busy source on any operand, or WAW on a busy destination
  always_comb begin
    w_stall = 1'b0;
    for (int i = 0; i < NLANES; i++)
      w_stall = w_stall | src_haz(Rs1D[i*REGBITS +: REGBITS]) | src_haz(Rs2D[i*REGBITS +: REGBITS]) |
                (RegWriteD[i] & r_busy[RdD[i*REGBITS +: REGBITS]] & ~w_clr[RdD[i*REGBITS +: REGBITS]]);
  end
  assign StallD = w_stall;
  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    assign w_v_m[g] = r_rw_m[g] & ~r_ll_m[g] & ~r_ld_m[g] & (r_rd_m[g*REGBITS +: REGBITS] != '0);
    assign w_v_w[g] = r_rw_w[g] & ~r_ll_w[g] & (r_rd_w[g*REGBITS +: REGBITS] != '0);
    vliw_fwd_pick #(.NLANES(NLANES), .REGBITS(REGBITS)) u_pick_a (
      .i_src(r_rs1_e[g*REGBITS +: REGBITS]), .i_rd_m(r_rd_m), .i_v_m(w_v_m),
      .i_rd_w(r_rd_w), .i_v_w(w_v_w),
      .o_fwd(ForwardAE[g*2 +: 2]), .o_sel(FwdSelRs1E[g*LANEBITS +: LANEBITS]));
    vliw_fwd_pick #(.NLANES(NLANES), .REGBITS(REGBITS)) u_pick_b (
      .i_src(r_rs2_e[g*REGBITS +: REGBITS]), .i_rd_m(r_rd_m), .i_v_m(w_v_m),
      .i_rd_w(r_rd_w), .i_v_w(w_v_w),
      .o_fwd(ForwardBE[g*2 +: 2]), .o_sel(FwdSelRs2E[g*LANEBITS +: LANEBITS]));
  end
endmodule

// File: doc/vliw_fwd_scoreboard.md
Name:
vliw_fwd_scoreboard

Overview:
Hazard/forwarding controller for the N-lane STARBUG VLIW integer pipeline, generalising the fixed 4-lane ForwardSelect scheme to NLANES lanes. It tracks every lane's destination register through E/M/W and computes per-lane ForwardAE/BE and lane-select codes, the source for each lane's datapath forwarding muxes. It also adds load-use detection and a long-latency scoreboard for MDU/FPU-divide results, which return out of band.

Parameters:
NLANES, 4, issue lanes per bundle (power of two, >=2); derived localparam LANEBITS = $clog2(NLANES)
NREGS, 32, architectural integer registers (16 when E_SUPPORTED); REGBITS = $clog2(NREGS)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
StallE  input  1  hold E pipeline register (whole bundle)
FlushE  input  1  bubble into E
StallM  input  1  hold M pipeline register
FlushM  input  1  bubble into M
StallW  input  1  hold W pipeline register
FlushW  input  1  bubble into W
Rs1D  input  NLANES*REGBITS  per-lane source 1, lane i at [i*REGBITS +: REGBITS]
Rs2D  input  NLANES*REGBITS  per-lane source 2
RdD  input  NLANES*REGBITS  per-lane destination
RegWriteD  input  NLANES  lane writes Rd
LoadD  input  NLANES  lane is a load (result available only in W)
LongLatD  input  NLANES  lane is multi-cycle (mul/div); result returns via LongDoneW
LongDoneW  input  NLANES  long-latency result writing regfile this cycle, per lane
LongRdW  input  NLANES*REGBITS  destination of completing long-latency result
ForwardAE  output  NLANES*2  per-lane operand A forward code
ForwardBE  output  NLANES*2  per-lane operand B forward code
FwdSelRs1E  output  NLANES*LANEBITS  source lane for operand A forward
FwdSelRs2E  output  NLANES*LANEBITS  source lane for operand B forward
StallD  output  1  bundle in D must stall (load-use, RAW/WAW on busy register)

Behaviour:
- Clock is clk; reset is synchronous, active-high. Reset clears all pipeline state and the busy vector. All outputs are 0 the cycle after reset. Reset mid-operation discards outstanding long-latency ops; busy returns to 0.
- Per-lane pipeline registers D->E->M->W hold Rs1/Rs2 (E only), Rd, RegWrite, Load, LongLat. Each register follows its stage: Flush (priority over stall) zeroes RegWrite/Load/LongLat; Stall holds; otherwise it loads.
- Effective forwardable write in stage S, lane j: RegWriteS[j] & ~LongLatS[j] & RdS[j]!=0.
- Forward codes: 00 = regfile, 01 = ResultW, 10 = IFResultM. For lane i operand A (B is identical with Rs2E):
  - Rs1E==0 -> 00, sel 0.
  - else if any lane j matches in M with ~LoadM[j] -> 10, sel = highest matching j (later slot is younger in program order).
  - else if any lane j matches in W -> 01, sel = highest matching j.
  - else 00, sel 0.
- M always beats W. A load match in M is not forwarded from M; it falls through to the W check, and the load-use stall prevents the hazard. Outputs are purely combinational from registered state: zero added latency.
- busy[NREGS] scoreboard:
  - Set busy[RdE[j]] on the E->M advance (~StallM & ~FlushM) when RegWriteE[j] & LongLatE[j] & RdE[j]!=0.
  - Clear busy[LongRdW[j]] when LongDoneW[j].
  - Simultaneous set and clear of the same register: set wins.
  - busy[0] is hardwired 0.
- StallD=1 if any lane i in D with its operand register !=0 meets any of:
  - a load-use hit: Rs1D/Rs2D matches RdE[j] of a lane with RegWriteE & (LoadE | LongLatE);
  - a busy source register that is not being cleared this cycle. Same-cycle release is allowed because the regfile writes on the negedge;
  - a WAW hit: RegWriteD[i] with busy[RdD[i]] not being cleared this cycle.
- StallD is combinational. Inserting the E bubble is left to the hazard unit.
- Intra-bundle RAW (lane i reads Rd of lane k in the same D bundle) is out of scope; the compiler guarantees it never occurs.

Decomposition:
- Shared package cvw (or vliw_pkg): typedef fwd_t with FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
- One sub-module vliw_fwd_pick: takes one source register plus per-lane M/W Rd/valid vectors and returns {fwd_t, lane select} with the highest-lane priority encoder. Instantiated 2*NLANES times.

Test Plan:
- Reset held 2 cycles mid-traffic with busy[12]=1 -> all outputs 0, busy cleared, StallD=0.
- Lane0 M writes x5, lane2 W writes x5, lane1 E Rs1=x5 -> ForwardAE[lane1]=10, FwdSelRs1E[lane1]=0.
- Lanes 1 and 3 in M both write x7, lane0 E Rs2=x7 -> ForwardBE[lane0]=10, FwdSelRs2E[lane0]=3. With Rs1=x0 -> ForwardAE=00.
- Load lane2 Rd=x9 in E, D lane0 Rs2=x9 -> StallD=1. Next cycle (E flushed, load in M) -> StallD=0, and the load's arrival in W yields ForwardBE=01, sel=2.
- Div lane1 Rd=x12 advances E->M -> busy[12]=1. D Rs1=x12 stalls every cycle until LongDoneW[1]=1 with LongRdW=12, when StallD=0 that same cycle.
- Set/clear collision: LongDoneW clears x12 while a new div writing x12 leaves E -> busy[12] stays 1. A lane writing x0 never forwards and never sets busy.
